// File: rtl/pipe_stage_reg.sv
// Purpose: pipeline stage register with valid/ready on both sides, optional 2-entry skid, flush, NOP-forced control, stats.
// Latency: one cycle from accept to output; full throughput while out_ready=1 for either SKID setting.
// Backpressure: SKID=1 in_ready is registered-state only (!skid full); SKID=0 in_ready = !main full | out_ready.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_ctrl     upstream handshake and payload
//   flush            drop all held entries and the current input
//   out_valid/out_ready/out_data/out_ctrl downstream handshake and head entry
//   occupancy        entries held (0..2)
//   bubble_cnt       saturating count of cycles with out_ready=1 and out_valid=0
module pipe_stage_reg #(
  parameter int unsigned           DATA_W   = 128,
  parameter int unsigned           CTRL_W   = 24,
  parameter logic [CTRL_W-1:0]     CTRL_NOP = '0,
  parameter bit                    SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [15:0]       bubble_cnt
);

  // Main slot (always the head) and skid slot.
  logic              m_vld;
  logic [DATA_W-1:0] m_dat;
  logic [CTRL_W-1:0] m_ctrl;
  logic              s_vld;
  logic [DATA_W-1:0] s_dat;
  logic [CTRL_W-1:0] s_ctrl;

  logic accept;
  logic drain;

  // With the skid slot, ready depends only on state so out_ready never
  // reaches in_ready combinationally; without it, ready passes through.
  assign in_ready  = SKID ? !s_vld : (!m_vld || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = m_vld && out_ready;

  assign out_valid = m_vld;
  assign out_data  = m_dat;
  assign out_ctrl  = m_vld ? m_ctrl : CTRL_NOP;
  assign occupancy = {1'b0, m_vld} + {1'b0, s_vld};

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld      <= 1'b0;
      m_dat      <= '0;
      m_ctrl     <= '0;
      s_vld      <= 1'b0;
      s_dat      <= '0;
      s_ctrl     <= '0;
      bubble_cnt <= '0;
    end else begin
      // Bubble statistic runs independently of flush.
      if (out_ready && !m_vld && (bubble_cnt != 16'hFFFF)) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end

      if (flush) begin
        // Payload registers are left as-is; only the valids matter.
        m_vld <= 1'b0;
        s_vld <= 1'b0;
      end else if (!m_vld) begin
        if (accept) begin
          m_vld  <= 1'b1;
          m_dat  <= in_data;
          m_ctrl <= in_ctrl;
        end
      end else if (drain) begin
        if (s_vld) begin
          // in_ready is low while S is full, so no accept can coincide here.
          m_dat  <= s_dat;
          m_ctrl <= s_ctrl;
          s_vld  <= 1'b0;
        end else if (accept) begin
          m_dat  <= in_data;
          m_ctrl <= in_ctrl;
        end else begin
          m_vld  <= 1'b0;
        end
      end else if (accept && SKID) begin
        // Head is stalled: park the incoming entry behind it.
        s_vld  <= 1'b1;
        s_dat  <= in_data;
        s_ctrl <= in_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose: directed self-checking bench for pipe_stage_reg, SKID=1 (u1) and SKID=0 (u0) side by side.
// Latency: checks sampled 1ns after each rising edge; inputs driven right after sampling.
// Backpressure: shared out_ready/flush/rst, separate upstream stimulus per instance.
module tb_pipe_stage_reg;

  localparam logic [3:0] NOP = 4'hA;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       out_ready;

  logic       v1, v0;
  logic [7:0] d1, d0;
  logic [3:0] c1, c0;

  logic       r1, r0;
  logic       ov1, ov0;
  logic [7:0] od1, od0;
  logic [3:0] oc1, oc0;
  logic [1:0] occ1, occ0;
  logic [15:0] bub1, bub0;

  int n_cmp;
  int n_err;

  pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .CTRL_NOP(NOP), .SKID(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_ctrl(c1),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_ctrl(oc1), .occupancy(occ1), .bubble_cnt(bub1)
  );

  pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .CTRL_NOP(NOP), .SKID(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0), .in_ctrl(c0),
    .flush(flush), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_ctrl(oc0), .occupancy(occ0), .bubble_cnt(bub0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0;
    v1 = 1'b0; v0 = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    v1 = 1'b0; v0 = 1'b0; d1 = '0; d0 = '0; c1 = '0; c0 = '0;

    // ---------------- reset then stream 1..8 ----------------
    cyc();
    chk("rst_ov1", ov1, 0);    chk("rst_ov0", ov0, 0);
    chk("rst_oc1", oc1, NOP);  chk("rst_oc0", oc0, NOP);
    chk("rst_od1", od1, 0);    chk("rst_od0", od0, 0);
    chk("rst_occ1", occ1, 0);  chk("rst_occ0", occ0, 0);
    chk("rst_bub1", bub1, 0);  chk("rst_bub0", bub0, 0);
    chk("rst_rdy1", r1, 1);    chk("rst_rdy0", r0, 1);
    cyc();
    rst = 1'b0;
    v1 = 1'b1; v0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      d1 = 8'(i); d0 = 8'(i);
      c1 = 4'(i) ^ 4'h5; c0 = 4'(i) ^ 4'h5;
      cyc();
      chk("str_ov1", ov1, 1);            chk("str_ov0", ov0, 1);
      chk("str_od1", od1, i);            chk("str_od0", od0, i);
      chk("str_oc1", oc1, (i ^ 5) & 15); chk("str_oc0", oc0, (i ^ 5) & 15);
      chk("str_occ1", occ1, 1);          chk("str_occ0", occ0, 1);
    end
    chk("str_bub1", bub1, 1); chk("str_bub0", bub0, 1);
    v1 = 1'b0; v0 = 1'b0;
    cyc();
    chk("str_end_ov1", ov1, 0);   chk("str_end_ov0", ov0, 0);
    chk("str_end_oc1", oc1, NOP); chk("str_end_oc0", oc0, NOP);

    // ---------------- stall, both SKID settings ----------------
    do_reset();
    // A presented with out_ready low
    out_ready = 1'b0;
    v1 = 1; d1 = 8'hA1; c1 = 4'h1;
    v0 = 1; d0 = 8'hA1; c0 = 4'h1;
    cyc();  // e1: A into M for both
    v1 = 1; d1 = 8'hB2; c1 = 4'h2;
    v0 = 1; d0 = 8'hB2; c0 = 4'h2;
    #1;
    chk("st1_od1", od1, 8'hA1); chk("st1_occ1", occ1, 1); chk("st1_rdy1", r1, 1);
    chk("st1_od0", od0, 8'hA1); chk("st1_rdy0", r0, 0);
    cyc();  // e2: u1 B into S; u0 holds
    v1 = 1; d1 = 8'hC3; c1 = 4'h3;
    chk("st2_od1", od1, 8'hA1); chk("st2_occ1", occ1, 2); chk("st2_rdy1", r1, 0);
    chk("st2_od0", od0, 8'hA1); chk("st2_occ0", occ0, 1); chk("st2_rdy0", r0, 0);
    cyc();  // e3: hold
    out_ready = 1'b1;
    #1;
    chk("st3_od1", od1, 8'hA1); chk("st3_oc1", oc1, 4'h1);
    chk("st3_occ1", occ1, 2);   chk("st3_rdy1", r1, 0);
    chk("st3_od0", od0, 8'hA1); chk("st3_occ0", occ0, 1); chk("st3_rdy0", r0, 1);
    cyc();  // e4: u1 A out, B to M; u0 A out, B in
    v0 = 1; d0 = 8'hC3; c0 = 4'h3;
    chk("st4_od1", od1, 8'hB2); chk("st4_oc1", oc1, 4'h2);
    chk("st4_occ1", occ1, 1);   chk("st4_rdy1", r1, 1);
    chk("st4_od0", od0, 8'hB2); chk("st4_occ0", occ0, 1);
    cyc();  // e5: C in for both
    v1 = 0; v0 = 0;
    chk("st5_od1", od1, 8'hC3); chk("st5_oc1", oc1, 4'h3);
    chk("st5_od0", od0, 8'hC3); chk("st5_occ0", occ0, 1);
    cyc();  // e6: drained
    chk("st6_ov1", ov1, 0); chk("st6_occ1", occ1, 0);
    chk("st6_ov0", ov0, 0); chk("st6_oc0", oc0, NOP);

    // ---------------- flush with two entries held ----------------
    do_reset();
    out_ready = 1'b0;
    v1 = 1; d1 = 8'h11; c1 = 4'h1;
    v0 = 1; d0 = 8'h11; c0 = 4'h1;
    cyc();
    v1 = 1; d1 = 8'h22; c1 = 4'h2;
    v0 = 0;
    cyc();
    chk("fl_pre_occ1", occ1, 2); chk("fl_pre_occ0", occ0, 1);
    v1 = 1; d1 = 8'h33; c1 = 4'h3;
    flush = 1'b1;
    cyc();
    flush = 1'b0; v1 = 0; out_ready = 1'b1;
    chk("fl_ov1", ov1, 0);   chk("fl_oc1", oc1, NOP);
    chk("fl_occ1", occ1, 0); chk("fl_rdy1", r1, 1);
    chk("fl_ov0", ov0, 0);   chk("fl_occ0", occ0, 0);
    cyc();
    chk("fl_gone_ov1", ov1, 0);
    v1 = 1; d1 = 8'h44; c1 = 4'h4;
    cyc();
    v1 = 0;
    chk("fl_next_od1", od1, 8'h44); chk("fl_next_ov1", ov1, 1);
    cyc();
    chk("fl_done_ov1", ov1, 0);

    // ---------------- bubble counting and saturation ----------------
    out_ready = 1'b0;
    do_reset();
    repeat (5) cyc();
    chk("bub_stall1", bub1, 0); chk("bub_stall0", bub0, 0);
    out_ready = 1'b1;
    repeat (65534) cyc();
    chk("bub_fffe1", bub1, 16'hFFFE); chk("bub_fffe0", bub0, 16'hFFFE);
    cyc();
    chk("bub_ffff1", bub1, 16'hFFFF); chk("bub_ffff0", bub0, 16'hFFFF);
    repeat (4465) cyc();
    chk("bub_sat1", bub1, 16'hFFFF); chk("bub_sat0", bub0, 16'hFFFF);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("bub_flush1", bub1, 16'hFFFF); chk("bub_flush0", bub0, 16'hFFFF);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("bub_clr1", bub1, 0); chk("bub_clr0", bub0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the general successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) in the MIPS pipeline. It carries an opaque data bundle and a control bundle between two stages. Each side has a valid/ready handshake, and the block adds an optional two-entry skid buffer, a flush that inserts a bubble, NOP-forcing of control on empty slots, and occupancy and bubble statistics. Hazard logic drives `flush` and `out_ready` (as the stall) from outside.

## Interface
- `DATA_W`, default 128: width of the data bundle (PC, operands, immediate, register indices).
- `CTRL_W`, default 24: width of the control bundle.
- `CTRL_NOP`, default 0: control value presented whenever no valid entry is at the output (encoded ALU_NOP / MEM_NOP / NPC_PLUS4, RegWrite=0, MemWrite=0).
- `SKID`, default 1: 1 selects a two-entry skid buffer; 0 selects a single register.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  block accepts this cycle.
- `in_data`  in  DATA_W  upstream data.
- `in_ctrl`  in  CTRL_W  upstream control.
- `flush`  in  1  discard all held entries and the current input.
- `out_valid`  out  1  downstream entry present.
- `out_ready`  in  1  downstream consumes; 0 means stall.
- `out_data`  out  DATA_W  head entry data.
- `out_ctrl`  out  CTRL_W  head entry control, or CTRL_NOP when out_valid=0.
- `occupancy`  out  2  number of entries held (0..2).
- `bubble_cnt`  out  16  saturating count of bubble cycles.

## Operation
- State: main slot M (valid, data, ctrl). When SKID=1 there is also a skid slot S with the same fields. M is always the head.
- Define accept = in_valid & in_ready and drain = out_valid & out_ready.
- in_ready depends on SKID:
  - SKID=1: in_ready = !S.valid. It is a function of state only, so there is no combinational path from out_ready.
  - SKID=0: in_ready = !M.valid | out_ready.
- out_valid = M.valid. out_data = M.data.
- out_ctrl = M.valid ? M.ctrl : CTRL_NOP. This is a combinational mux on registered state.
- Update rules at each edge, highest priority first:
  - rst: M.valid=0, S.valid=0, all data and ctrl regs=0, bubble_cnt=0.
  - flush: M.valid=0 and S.valid=0. A same-cycle accept is dropped. Data regs are unchanged.
  - M empty, accept: M loads the input.
  - M full, drain, S full: M takes S and S empties. No accept is possible in this case.
  - M full, drain, S empty: if accept, M loads the input; otherwise M empties.
  - M full, no drain, accept (SKID=1 only): S loads the input.
  - Otherwise: hold.
- Ordering is strict FIFO. No entry is duplicated or lost except by flush.
- occupancy = M.valid + S.valid. With SKID=0 it is never greater than 1.
- bubble_cnt increments by 1 on each cycle where out_ready=1 and out_valid=0, is not rst, and the count is below 16'hFFFF. It saturates at 16'hFFFF. Flush does not clear it.

## Timing
- Reset values (one edge after rst=1):
  - out_valid=0, out_ctrl=CTRL_NOP, out_data=0.
  - occupancy=0, bubble_cnt=0.
  - in_ready=1.
- Latency: an input accepted at edge N appears at the output during cycle N+1.
- Throughput: one entry per cycle while out_ready=1, for both SKID settings.
- Stall with SKID=1:
  - The first held-up input is captured in S.
  - in_ready drops one cycle after out_ready drops.
  - in_ready rises the cycle after S drains into M.
- Flush and stall in the same cycle: flush wins, and the block is empty next cycle.
- rst asserted mid-stream: all entries are lost at that edge. out_valid=0 starting the next cycle.
- flush asserted with in_valid=1: in_ready is still driven per the rules above, but the entry is discarded. Upstream must treat it as consumed.

## Test plan
- Reset then stream: rst for 2 cycles, then values 1..8 with out_ready=1 -> outputs 1..8 in order, one per cycle, each one cycle after input. occupancy stays at 1 and bubble_cnt=1 (the first cycle after reset).
- Stall with SKID=1: stream A,B,C and drop out_ready at the cycle A is presented, for 3 cycles -> A held at the output, B in S, in_ready=0 and occupancy=2. On release the output is A, B, C in consecutive cycles.
- Stall with SKID=0: the same stimulus -> in_ready equals out_ready combinationally, no entry is lost, and occupancy is never above 1.
- Flush: with occupancy=2 and in_valid=1, pulse flush for one cycle -> next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy=0, and the flushed input never appears.
- Saturation: hold out_ready=1 and in_valid=0 for 70000 cycles -> bubble_cnt=16'hFFFF and it stays there. rst then clears it to 0.
- Random ready/valid/flush for 10^5 cycles against a reference FIFO model -> identical output sequence, and out_ctrl=CTRL_NOP on every cycle where out_valid=0.
